mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single 8x8 synchronous-read memory between two requesters: port 0, the host load/readback path, and port 1, the sort engine. It picks one access per cycle with round-robin fairness and drives the memory's read/write command lines. A requester can lock the memory for a multi-cycle sequence, bounded by a watchdog. It sits between the requesters and the memory instance in the sorting circuit.

## Interface
- ADDR_W, 3, memory address width (8 entries)
- DATA_W, 8, data width
- MAX_LOCK, 64, maximum cycles a lock may be held before forced release (≥2)

- clk  in  1  single clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- wr0 / wr1  in  1  1 = write, 0 = read; qualifies req
- lock0 / lock1  in  1  request exclusive ownership after this access
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  rdata holds this port's read result
- rdata  out  DATA_W  shared read data, equals mem_out
- lock_err  out  1  one-cycle pulse on watchdog-forced release
- mem_rd, mem_wr  out  1  memory read and write enables
- mem_rdaddr, mem_wraddr  out  ADDR_W  memory addresses
- mem_in  out  DATA_W  memory write data
- mem_out  in  DATA_W  memory registered read data

## Operation
- Owner FSM has three states: IDLE, OWN0, OWN1. The round-robin pointer prio (0 or 1) names the port that wins a tie.
- IDLE arbitration:
  - If only one port requests, it is granted.
  - If both request, port prio is granted.
  - prio is not updated in this state except as below.
- Any grant to port k sets prio to the other port at the next edge.
- Lock entry: if gnt_k and lock_k are both 1 at an edge, the FSM goes to OWNk.
- OWNk behaviour:
  - Only port k can be granted; the other port's gnt is 0 even if it requests.
  - If lock_k is 0 at an edge, the FSM returns to IDLE. If req_k is also high that cycle, that final access is still granted.
- Watchdog:
  - Counter is cleared on entry to OWNk and increments each cycle in OWNk.
  - When the counter reaches MAX_LOCK-1 while lock_k is still 1, the FSM is forced to IDLE, prio is set to the other port, and lock_err pulses for one cycle.
  - lock_k must drop before the same port can lock again. A re-lock needs a fresh lock_k rising with a grant.
- Memory command decode:
  - mem_rd = granted & !wr; mem_wr = granted & wr.
  - Both addresses come from the winner's addr; mem_in is the winner's wdata.
  - With no grant, all memory outputs are 0.
- At most one access is issued per cycle, so a read and a write can never collide on the memory.
- rvalid_k is a register of (gnt_k & !wr_k).

## Timing
- Reset (asynchronous): FSM = IDLE, prio = 0, watchdog = 0, rvalid0 = rvalid1 = 0, lock_err = 0.
- The grant is combinational in the request cycle. The memory samples the command at the following edge.
- Read latency: one cycle. rvalid_k and valid rdata appear in the cycle after the grant.
- Back-to-back grants are allowed every cycle. A continuous stream of reads gives a continuous rvalid.
- Lock release: in the cycle after the exit edge the FSM is in IDLE, and the other port can be granted in that cycle, not earlier.
- Reset mid-lock or with a read in flight: the FSM drops to IDLE, and a pending rvalid is discarded (forced to 0).
- Requester fields must stay stable while req is high and gnt is 0.

## Test plan
- Reset, then req0 write addr 3 data 0x5A, then req0 read addr 3:
  - gnt0 is 1 in the same cycle as each request.
  - rvalid0 = 1 with rdata = 0x5A one cycle after the read grant.
- req0 and req1 both held high for 4 cycles, reads, prio = 0 after reset:
  - grants go gnt0, gnt1, gnt0, gnt1.
  - rvalid follows each grant one cycle later.
- Port 1 locks at cycle 0 and holds for 5 cycles while req0 stays high:
  - gnt0 stays 0 throughout the lock.
  - lock1 drops at cycle 5; gnt0 = 1 at cycle 6.
- Port 1 holds lock1 for MAX_LOCK+2 cycles:
  - lock_err pulses once, MAX_LOCK cycles after lock entry.
  - FSM returns to IDLE; pending req0 is granted the next cycle.
- Port 0 is locked with a read granted; nrst is asserted one cycle later:
  - rvalid0 = 0, gnt outputs follow IDLE arbitration, prio = 0.
  - After reset release, req1 alone is granted immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the two-port memory arbiter.
// Latency: none; this is wiring only.
// Backpressure: req is held by the requester until gnt; no other flow control.
// Ports: req/wr/lock/addr/wdata per requester, gnt/rvalid per requester, shared rdata,
//        lock_err pulse, memory command lines (mem_rd/mem_wr/addresses/mem_in) and mem_out.
interface mem_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic              lock0;
    logic              lock1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              lock_err;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_rdaddr;
    logic [ADDR_W-1:0] mem_wraddr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    // Arbiter side.
    modport slave (
        input  req0, req1, wr0, wr1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, lock_err,
        output mem_rd, mem_wr, mem_rdaddr, mem_wraddr, mem_in
    );

    // Requesters plus memory side.
    modport master (
        output req0, req1, wr0, wr1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, lock_err,
        input  mem_rd, mem_wr, mem_rdaddr, mem_wraddr, mem_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of a single synchronous-read memory, with lock and watchdog.
// Latency: grant is combinational in the request cycle; read data and rvalid one cycle after grant.
// Backpressure: a requester holds req (fields stable) until gnt; a locked port excludes the other.
// Ports: clk, nrst (async active-low), bus (mem_arbiter_if.slave) carrying both requesters,
//        the memory command lines, mem_out, shared rdata, rvalid0/1 and the lock_err pulse.
module mem_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 64
) (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // A port whose lock was forcibly broken may not re-lock until it drops lock once.
    logic [1:0]         blk_q, blk_d;
    logic               err_q, err_d;
    logic               rv0_q, rv1_q;
    logic               gnt0, gnt1;
    logic               mem_rd, mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_in;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            blk_q   <= 2'b00;
            err_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
            rv0_q   <= gnt0 & ~bus.wr0;
            rv1_q   <= gnt1 & ~bus.wr1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        blk_d   = blk_q & {bus.lock1, bus.lock0};
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt0 && bus.lock0 && !blk_q[0]) begin
                    state_d = OWN0;
                end else if (gnt1 && bus.lock1 && !blk_q[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!bus.lock0) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    prio_d   = 1'b1;
                    err_d    = 1'b1;
                    blk_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OWN1: begin
                if (!bus.lock1) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    prio_d   = 1'b0;
                    err_d    = 1'b1;
                    blk_d[1] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: grants and the winner's memory command.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    gnt0 = ~prio_q;
                    gnt1 = prio_q;
                end else begin
                    gnt0 = bus.req0;
                    gnt1 = bus.req1;
                end
            end
            OWN0:    gnt0 = bus.req0;
            OWN1:    gnt1 = bus.req1;
            default: ;
        endcase

        mem_rd   = (gnt0 & ~bus.wr0) | (gnt1 & ~bus.wr1);
        mem_wr   = (gnt0 &  bus.wr0) | (gnt1 &  bus.wr1);
        mem_addr = '0;
        mem_in   = '0;
        if (gnt0) begin
            mem_addr = bus.addr0;
            mem_in   = bus.wdata0;
        end else if (gnt1) begin
            mem_addr = bus.addr1;
            mem_in   = bus.wdata1;
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.rvalid0    = rv0_q;
    assign bus.rvalid1    = rv1_q;
    assign bus.rdata      = bus.mem_out;
    assign bus.lock_err   = err_q;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.mem_rdaddr = mem_addr;
    assign bus.mem_wraddr = mem_addr;
    assign bus.mem_in     = mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written lock/watchdog/reset sequences, random run vs model.
// Latency: inputs applied 1 time unit after each rising edge, outputs sampled 3 units later.
// Backpressure: random requesters hold their fields until the model says they were granted.
module tb_mem_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int ML = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // 8x8 synchronous-read memory.
    logic [DW-1:0] mem [0:7];
    logic [DW-1:0] mem_q;
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_wraddr] <= bus.mem_in;
        if (bus.mem_rd) mem_q <= mem[bus.mem_rdaddr];
    end
    assign bus.mem_out = mem_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit r1, input bit w0, input bit w1,
                         input bit l0, input bit l1, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1);
        bus.req0 = r0;   bus.req1 = r1;
        bus.wr0 = w0;    bus.wr1 = w1;
        bus.lock0 = l0;  bus.lock1 = l1;
        bus.addr0 = a0;  bus.addr1 = a1;
        bus.wdata0 = d0; bus.wdata1 = d1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        nrst = 1'b1;
    endtask

    typedef struct {
        bit            rst;
        bit            r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        bit            g0, g1, v0, v1;
        bit            chk_d;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs [10];

    // Reference model state.
    int            m_owner;
    int            m_prio;
    int            m_held;
    bit            m_blk [2];
    bit            m_rv  [2];
    bit            m_err;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_mem [8];
    int            last_win;

    task automatic model_cycle();
        bit            r [2];
        bit            w [2];
        bit            l [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            win;
        r[0] = bus.req0;   r[1] = bus.req1;
        w[0] = bus.wr0;    w[1] = bus.wr1;
        l[0] = bus.lock0;  l[1] = bus.lock1;
        a[0] = bus.addr0;  a[1] = bus.addr1;
        d[0] = bus.wdata0; d[1] = bus.wdata1;

        if (m_owner < 0) begin
            if (r[0] && r[1]) win = m_prio;
            else if (r[0])    win = 0;
            else if (r[1])    win = 1;
            else              win = -1;
        end else begin
            win = r[m_owner] ? m_owner : -1;
        end

        chk("rnd_gnt0", bus.gnt0, win == 0);
        chk("rnd_gnt1", bus.gnt1, win == 1);
        chk("rnd_rv0", bus.rvalid0, m_rv[0]);
        chk("rnd_rv1", bus.rvalid1, m_rv[1]);
        if (m_rv[0] || m_rv[1]) chk("rnd_rdata", bus.rdata, m_rdata);
        chk("rnd_lock_err", bus.lock_err, m_err);
        chk("rnd_mem_rd", bus.mem_rd, win >= 0 && !w[win >= 0 ? win : 0]);
        chk("rnd_mem_wr", bus.mem_wr, win >= 0 && w[win >= 0 ? win : 0]);
        if (win >= 0) begin
            chk("rnd_rdaddr", bus.mem_rdaddr, a[win]);
            chk("rnd_wraddr", bus.mem_wraddr, a[win]);
            if (w[win]) chk("rnd_mem_in", bus.mem_in, d[win]);
        end else begin
            chk("rnd_idle_cmd", {bus.mem_rdaddr, bus.mem_wraddr, bus.mem_in}, 0);
        end

        // Advance the model across the clock edge.
        m_err = 1'b0;
        for (int k = 0; k < 2; k++) if (!l[k]) m_blk[k] = 1'b0;
        m_rv[0] = (win == 0) && !w[0];
        m_rv[1] = (win == 1) && !w[1];
        if (win >= 0) begin
            m_prio = 1 - win;
            if (w[win]) m_mem[a[win]] = d[win];
            else        m_rdata = m_mem[a[win]];
        end
        if (m_owner < 0) begin
            if (win >= 0 && l[win] && !m_blk[win]) begin
                m_owner = win;
                m_held  = 0;
            end
        end else begin
            m_held++;
            if (!l[m_owner]) begin
                m_owner = -1;
            end else if (m_held == ML) begin
                m_prio         = 1 - m_owner;
                m_blk[m_owner] = 1'b1;
                m_err          = 1'b1;
                m_owner        = -1;
            end
        end
        last_win = win;
    endtask

    bit            s_req  [2];
    bit            s_wr   [2];
    bit            s_lock [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_data [2];

    initial begin
        int errs;
        int err_at;
        int g0_first;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //           rst r0 r1 w0 w1 a0 a1 d0     d1     g0 g1 v0 v1 chk rd
        vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        vecs[1] = '{0, 1, 0, 1, 0, 3, 0, 8'h5A, 8'h00, 1, 0, 0, 0, 0, 8'h00};
        vecs[2] = '{0, 1, 0, 0, 0, 3, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00};
        vecs[3] = '{0, 0, 1, 0, 1, 0, 5, 8'h00, 8'hA5, 0, 1, 1, 0, 1, 8'h5A};
        vecs[4] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        vecs[5] = '{0, 1, 1, 0, 0, 3, 5, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00};
        vecs[6] = '{0, 1, 1, 0, 0, 3, 5, 8'h00, 8'h00, 0, 1, 1, 0, 1, 8'h5A};
        vecs[7] = '{0, 1, 1, 0, 0, 3, 5, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'hA5};
        vecs[8] = '{0, 1, 1, 0, 0, 3, 5, 8'h00, 8'h00, 0, 1, 1, 0, 1, 8'h5A};
        vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'hA5};

        for (int i = 0; i < 10; i++) begin
            cyc();
            nrst = !vecs[i].rst;
            drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, 0, 0,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            #3;
            chk($sformatf("vec%0d_gnt0", i), bus.gnt0, vecs[i].g0);
            chk($sformatf("vec%0d_gnt1", i), bus.gnt1, vecs[i].g1);
            chk($sformatf("vec%0d_rv0", i), bus.rvalid0, vecs[i].v0);
            chk($sformatf("vec%0d_rv1", i), bus.rvalid1, vecs[i].v1);
            chk($sformatf("vec%0d_mem_wr", i), bus.mem_wr,
                (vecs[i].g0 & vecs[i].w0) | (vecs[i].g1 & vecs[i].w1));
            if (vecs[i].chk_d) chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].rd);
        end

        // Port 1 locks; port 0 starves until one cycle after lock1 drops.
        do_reset();
        cyc();
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        #3;
        chk("lk_c0_gnt1", bus.gnt1, 1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            drive(1, 1, 0, 0, 0, 1, 2, 0, 0, 0);
            #3;
            chk($sformatf("lk_c%0d_gnt0", c), bus.gnt0, 0);
            chk($sformatf("lk_c%0d_gnt1", c), bus.gnt1, 1);
        end
        cyc();
        drive(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        #3;
        chk("lk_c5_gnt0", bus.gnt0, 0);
        cyc();
        #3;
        chk("lk_c6_gnt0", bus.gnt0, 1);

        // Watchdog: lock1 held past MAX_LOCK cycles.
        do_reset();
        cyc();
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        #3;
        chk("wd_entry_gnt1", bus.gnt1, 1);
        errs = 0;
        err_at = -1;
        g0_first = -1;
        for (int c = 1; c <= ML + 2; c++) begin
            cyc();
            drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
            #3;
            if (bus.lock_err) begin
                errs++;
                err_at = c;
            end
            if (bus.gnt0 && g0_first < 0) g0_first = c;
        end
        chk("wd_err_count", errs, 1);
        chk("wd_err_cycle", err_at, ML + 1);
        chk("wd_gnt0_cycle", g0_first, ML + 1);
        cyc();
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        #3;
        chk("wd_relock_gnt1", bus.gnt1, 1);
        cyc();
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        #3;
        chk("wd_no_relock_gnt0", bus.gnt0, 1);

        // Reset while port 0 owns the memory with a read in flight.
        do_reset();
        cyc();
        drive(1, 0, 0, 0, 1, 0, 3, 0, 0, 0);
        #3;
        chk("rl_c0_gnt0", bus.gnt0, 1);
        cyc();
        #3;
        chk("rl_c1_gnt0", bus.gnt0, 1);
        cyc();
        nrst = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("rl_rst_rv0", bus.rvalid0, 0);
        chk("rl_rst_gnt1", bus.gnt1, 1);
        cyc();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("rl_rst_prio_gnt0", bus.gnt0, 1);
        chk("rl_rst_prio_gnt1", bus.gnt1, 0);
        cyc();
        nrst = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("rl_post_gnt1", bus.gnt1, 1);

        // Random run against the model, after prefilling every address.
        do_reset();
        m_owner = -1;
        m_prio  = 0;
        m_held  = 0;
        m_err   = 1'b0;
        m_rdata = '0;
        last_win = -1;
        for (int k = 0; k < 2; k++) begin
            m_blk[k] = 1'b0;
            m_rv[k]  = 1'b0;
            s_req[k] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(1, 0, 1, 0, 0, 0, AW'(i), 0, DW'($urandom), 0);
            #3;
            model_cycle();
        end
        for (int n = 0; n < 3000; n++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                if (!(s_req[k] && last_win != k)) begin
                    s_req[k]  = ($urandom_range(0, 3) != 0);
                    s_wr[k]   = 1'($urandom_range(0, 1));
                    s_addr[k] = AW'($urandom);
                    s_data[k] = DW'($urandom);
                    if (m_owner == k) s_lock[k] = ($urandom_range(0, 15) != 0);
                    else              s_lock[k] = ($urandom_range(0, 5) == 0);
                end
            end
            drive(s_req[0], s_req[1], s_wr[0], s_wr[1], s_lock[0], s_lock[1],
                  s_addr[0], s_addr[1], s_data[0], s_data[1]);
            #3;
            model_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
